// File: rtl/scr1_imem_branch_tracer.sv
// Pairs accepted imem fetches with their in-order responses and traces conditional branches.
// Latency: record, counters and pend_cnt register one cycle after the response/transfer; never backpressures the bus.
module scr1_imem_branch_tracer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     imem_req,
    input  logic                     imem_req_ack,
    input  logic [31:0]              imem_addr,
    input  logic [1:0]               imem_resp,
    input  logic [31:0]              imem_rdata,
    input  logic                     cnt_clr,
    output logic                     br_vld,
    output logic [31:0]              br_addr,
    output logic [31:0]              br_instr,
    output logic [1:0]               br_kind,
    output logic [CNT_W-1:0]         beq_cnt,
    output logic [CNT_W-1:0]         bne_cnt,
    output logic [CNT_W-1:0]         blt_cnt,
    output logic [CNT_W-1:0]         bltu_cnt,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [$clog2(DEPTH):0]   pend_cnt,
    output logic                     proto_err
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      pend_q, pend_d;
    logic             br_vld_q, br_vld_d;
    logic [31:0]      br_addr_q, br_addr_d;
    logic [31:0]      br_instr_q, br_instr_d;
    logic [1:0]       br_kind_q, br_kind_d;
    logic [CNT_W-1:0] beq_q, beq_d, bne_q, bne_d, blt_q, blt_d, bltu_q, bltu_d, err_q, err_d;
    logic             proto_err_q, proto_err_d;

    logic       xfer, resp_any, fifo_empty, fifo_full, push, pop, violation;
    logic       resp_ok, resp_err, is_branch, rec;
    logic [2:0] funct3;
    logic [1:0] kind;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        xfer       = imem_req & imem_req_ack;
        resp_any   = (imem_resp != 2'b00);
        fifo_empty = (pend_q == '0);
        fifo_full  = (pend_q == (AW+1)'(DEPTH));
        pop        = resp_any & ~fifo_empty;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push       = xfer & (~fifo_full | pop);
        violation  = (resp_any & fifo_empty) | (xfer & fifo_full & ~pop);

        funct3    = imem_rdata[14:12];
        is_branch = (imem_rdata[6:0] == 7'b1100011) && (funct3[2:1] != 2'b01);
        kind      = {funct3[2], funct3[2] ? funct3[1] : funct3[0]};
        resp_ok   = pop & (imem_resp == 2'b01);
        resp_err  = pop & imem_resp[1];
        rec       = resp_ok & is_branch;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   pend_d = pend_q + (AW+1)'(1);
            2'b01:   pend_d = pend_q - (AW+1)'(1);
            default: pend_d = pend_q;
        endcase

        br_vld_d   = rec;
        br_addr_d  = rec ? mem_q[rd_ptr_q] : br_addr_q;
        br_instr_d = rec ? imem_rdata      : br_instr_q;
        br_kind_d  = rec ? kind            : br_kind_q;

        beq_d  = (rec && kind == 2'b00) ? sat_inc(beq_q)  : beq_q;
        bne_d  = (rec && kind == 2'b01) ? sat_inc(bne_q)  : bne_q;
        blt_d  = (rec && kind == 2'b10) ? sat_inc(blt_q)  : blt_q;
        bltu_d = (rec && kind == 2'b11) ? sat_inc(bltu_q) : bltu_q;
        err_d  = resp_err ? sat_inc(err_q) : err_q;
        proto_err_d = proto_err_q | violation;
        if (cnt_clr) begin
            beq_d       = '0;
            bne_d       = '0;
            blt_d       = '0;
            bltu_d      = '0;
            err_d       = '0;
            proto_err_d = 1'b0;
        end
    end

    // Address storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= imem_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pend_q      <= '0;
            br_vld_q    <= 1'b0;
            br_addr_q   <= '0;
            br_instr_q  <= '0;
            br_kind_q   <= '0;
            beq_q       <= '0;
            bne_q       <= '0;
            blt_q       <= '0;
            bltu_q      <= '0;
            err_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pend_q      <= pend_d;
            br_vld_q    <= br_vld_d;
            br_addr_q   <= br_addr_d;
            br_instr_q  <= br_instr_d;
            br_kind_q   <= br_kind_d;
            beq_q       <= beq_d;
            bne_q       <= bne_d;
            blt_q       <= blt_d;
            bltu_q      <= bltu_d;
            err_q       <= err_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign br_vld    = br_vld_q;
    assign br_addr   = br_addr_q;
    assign br_instr  = br_instr_q;
    assign br_kind   = br_kind_q;
    assign beq_cnt   = beq_q;
    assign bne_cnt   = bne_q;
    assign blt_cnt   = blt_q;
    assign bltu_cnt  = bltu_q;
    assign err_cnt   = err_q;
    assign pend_cnt  = pend_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_scr1_imem_branch_tracer.sv
// Directed vector bench for scr1_imem_branch_tracer (DEPTH=4, CNT_W=4 so saturation is reachable).
module tb_scr1_imem_branch_tracer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst, imem_req, imem_req_ack, cnt_clr;
    logic [31:0]       imem_addr, imem_rdata;
    logic [1:0]        imem_resp;
    logic              br_vld, proto_err;
    logic [31:0]       br_addr, br_instr;
    logic [1:0]        br_kind;
    logic [CNT_W-1:0]  beq_cnt, bne_cnt, blt_cnt, bltu_cnt, err_cnt;
    logic [2:0]        pend_cnt;

    scr1_imem_branch_tracer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_req_ack(imem_req_ack),
        .imem_addr(imem_addr), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .cnt_clr(cnt_clr), .br_vld(br_vld), .br_addr(br_addr), .br_instr(br_instr),
        .br_kind(br_kind), .beq_cnt(beq_cnt), .bne_cnt(bne_cnt), .blt_cnt(blt_cnt),
        .bltu_cnt(bltu_cnt), .err_cnt(err_cnt), .pend_cnt(pend_cnt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, req, ack;
        logic [31:0] addr;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        clr;
        logic        e_vld;
        logic [31:0] e_addr, e_instr;
        logic [1:0]  e_kind;
        int          e_pend;
        logic        e_perr;
        int          e_beq, e_bne, e_blt, e_bltu, e_err;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    localparam logic [31:0] BNE_W  = 32'h00B51463;
    localparam logic [31:0] BEQ_W  = 32'h00000063;
    localparam logic [31:0] ADDI_W = 32'h00100093;
    localparam logic [31:0] BLTU_W = 32'h0000E063;
    localparam logic [31:0] BLT_W  = 32'h00004063;
    localparam logic [31:0] F3_2_W = 32'h00002063;
    localparam logic [31:0] BNE2_W = 32'h00001063;

    function automatic vec_t v(
        logic r, logic rq, logic ak, logic [31:0] a, logic [1:0] rs, logic [31:0] rd, logic c,
        logic ev, logic [31:0] ea, logic [31:0] ei, logic [1:0] ek, int ep, logic epe,
        int eq, int en, int el, int elu, int ee);
        vec_t t;
        t.rst = r; t.req = rq; t.ack = ak; t.addr = a; t.resp = rs; t.rdata = rd; t.clr = c;
        t.e_vld = ev; t.e_addr = ea; t.e_instr = ei; t.e_kind = ek; t.e_pend = ep;
        t.e_perr = epe; t.e_beq = eq; t.e_bne = en; t.e_blt = el; t.e_bltu = elu; t.e_err = ee;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    endtask

    initial begin
        logic [31:0] la, li;
        logic [1:0]  lk;
        rst = 1'b1; imem_req = 0; imem_req_ack = 0; imem_addr = 0;
        imem_resp = 0; imem_rdata = 0; cnt_clr = 0;

        // reset, then traffic during reset is discarded
        vq.push_back(v(1,0,0,0,     0,0,     0, 0,0,0,0, 0,0, 0,0,0,0,0));
        vq.push_back(v(1,1,1,32'h55,1,BNE_W, 0, 0,0,0,0, 0,0, 0,0,0,0,0));
        // single BNE fetch
        vq.push_back(v(0,1,1,32'h200,0,0,    0, 0,0,0,0, 1,0, 0,0,0,0,0));
        vq.push_back(v(0,0,0,0,     1,BNE_W, 0, 1,32'h200,BNE_W,1, 0,0, 0,1,0,0,0));
        vq.push_back(v(0,1,0,32'hDEAD,0,0,   0, 0,32'h200,BNE_W,1, 0,0, 0,1,0,0,0));
        // four pipelined requests, mixed responses back-to-back
        vq.push_back(v(0,1,1,32'h100,0,0,    0, 0,32'h200,BNE_W,1, 1,0, 0,1,0,0,0));
        vq.push_back(v(0,1,1,32'h104,0,0,    0, 0,32'h200,BNE_W,1, 2,0, 0,1,0,0,0));
        vq.push_back(v(0,1,1,32'h108,0,0,    0, 0,32'h200,BNE_W,1, 3,0, 0,1,0,0,0));
        vq.push_back(v(0,1,1,32'h10C,0,0,    0, 0,32'h200,BNE_W,1, 4,0, 0,1,0,0,0));
        vq.push_back(v(0,0,0,0,     1,BEQ_W, 0, 1,32'h100,BEQ_W,0, 3,0, 1,1,0,0,0));
        vq.push_back(v(0,0,0,0,     1,ADDI_W,0, 0,32'h100,BEQ_W,0, 2,0, 1,1,0,0,0));
        vq.push_back(v(0,0,0,0,     1,BLTU_W,0, 1,32'h108,BLTU_W,3,1,0, 1,1,0,1,0));
        vq.push_back(v(0,0,0,0,     2,BEQ_W, 0, 0,32'h108,BLTU_W,3,0,0, 1,1,0,1,1));
        // BLT kind, funct3=010 non-branch, reserved response counts as error
        vq.push_back(v(0,1,1,32'h300,0,0,    0, 0,32'h108,BLTU_W,3,1,0, 1,1,0,1,1));
        vq.push_back(v(0,0,0,0,     1,BLT_W, 0, 1,32'h300,BLT_W,2, 0,0, 1,1,1,1,1));
        vq.push_back(v(0,1,1,32'h304,0,0,    0, 0,32'h300,BLT_W,2, 1,0, 1,1,1,1,1));
        vq.push_back(v(0,0,0,0,     1,F3_2_W,0, 0,32'h300,BLT_W,2, 0,0, 1,1,1,1,1));
        vq.push_back(v(0,1,1,32'h308,0,0,    0, 0,32'h300,BLT_W,2, 1,0, 1,1,1,1,1));
        vq.push_back(v(0,0,0,0,     3,BEQ_W, 0, 0,32'h300,BLT_W,2, 0,0, 1,1,1,1,2));
        // response with empty FIFO, then clear
        vq.push_back(v(0,0,0,0,     1,BEQ_W, 0, 0,32'h300,BLT_W,2, 0,1, 1,1,1,1,2));
        vq.push_back(v(0,0,0,0,     0,0,     1, 0,32'h300,BLT_W,2, 0,0, 0,0,0,0,0));
        // fill, overflow drops 0x410, then full push+pop keeps order
        vq.push_back(v(0,1,1,32'h400,0,0,    0, 0,32'h300,BLT_W,2, 1,0, 0,0,0,0,0));
        vq.push_back(v(0,1,1,32'h404,0,0,    0, 0,32'h300,BLT_W,2, 2,0, 0,0,0,0,0));
        vq.push_back(v(0,1,1,32'h408,0,0,    0, 0,32'h300,BLT_W,2, 3,0, 0,0,0,0,0));
        vq.push_back(v(0,1,1,32'h40C,0,0,    0, 0,32'h300,BLT_W,2, 4,0, 0,0,0,0,0));
        vq.push_back(v(0,1,1,32'h410,0,0,    0, 0,32'h300,BLT_W,2, 4,1, 0,0,0,0,0));
        vq.push_back(v(0,0,0,0,     0,0,     1, 0,32'h300,BLT_W,2, 4,0, 0,0,0,0,0));
        vq.push_back(v(0,1,1,32'h414,1,BEQ_W,0, 1,32'h400,BEQ_W,0, 4,0, 1,0,0,0,0));
        vq.push_back(v(0,0,0,0,     1,BEQ_W, 0, 1,32'h404,BEQ_W,0, 3,0, 2,0,0,0,0));
        vq.push_back(v(0,0,0,0,     1,BEQ_W, 0, 1,32'h408,BEQ_W,0, 2,0, 3,0,0,0,0));
        vq.push_back(v(0,0,0,0,     1,BEQ_W, 0, 1,32'h40C,BEQ_W,0, 1,0, 4,0,0,0,0));
        vq.push_back(v(0,0,0,0,     1,BEQ_W, 0, 1,32'h414,BEQ_W,0, 0,0, 5,0,0,0,0));
        // empty FIFO: simultaneous push and response is an error, push still lands
        vq.push_back(v(0,1,1,32'h500,1,BEQ_W,0, 0,32'h414,BEQ_W,0, 1,1, 5,0,0,0,0));
        vq.push_back(v(0,0,0,0,     1,BNE2_W,0, 1,32'h500,BNE2_W,1,0,1, 5,1,0,0,0));
        vq.push_back(v(0,0,0,0,     0,0,     1, 0,32'h500,BNE2_W,1,0,0, 0,0,0,0,0));
        // 20 BNE fetches saturate the 4-bit counter at 15
        la = 32'h500; li = BNE2_W; lk = 2'b01;
        for (int i = 0; i < 20; i++) begin
            vq.push_back(v(0,1,1,32'h700+32'(4*i),0,0, 0, 0,la,li,lk, 1,0, 0,(i < 15) ? i : 15,0,0,0));
            la = 32'h700 + 32'(4*i); li = BNE_W; lk = 2'b01;
            vq.push_back(v(0,0,0,0,1,BNE_W,0, 1,la,li,lk, 0,0, 0,(i + 1 < 15) ? i + 1 : 15,0,0,0));
        end
        // clear wins over a coincident increment; trace still updates
        vq.push_back(v(0,1,1,32'h800,0,0,    0, 0,la,li,lk, 1,0, 0,15,0,0,0));
        vq.push_back(v(0,0,0,0,     1,BNE_W, 1, 1,32'h800,BNE_W,1, 0,0, 0,0,0,0,0));
        // reset mid-burst flushes pending entries; late response is a protocol error
        vq.push_back(v(0,1,1,32'h900,0,0,    0, 0,32'h800,BNE_W,1, 1,0, 0,0,0,0,0));
        vq.push_back(v(0,1,1,32'h904,2,0,    0, 0,32'h800,BNE_W,1, 1,0, 0,0,0,0,1));
        vq.push_back(v(0,1,1,32'h908,0,0,    0, 0,32'h800,BNE_W,1, 2,0, 0,0,0,0,1));
        vq.push_back(v(1,0,0,0,     0,0,     0, 0,0,0,0, 0,0, 0,0,0,0,0));
        vq.push_back(v(0,0,0,0,     1,BEQ_W, 0, 0,0,0,0, 0,1, 0,0,0,0,0));
        vq.push_back(v(0,0,0,0,     0,0,     0, 0,0,0,0, 0,1, 0,0,0,0,0));

        foreach (vq[i]) begin
            rst = vq[i].rst; imem_req = vq[i].req; imem_req_ack = vq[i].ack;
            imem_addr = vq[i].addr; imem_resp = vq[i].resp; imem_rdata = vq[i].rdata;
            cnt_clr = vq[i].clr;
            @(posedge clk);
            #1;
            chk("br_vld",    i, 32'(br_vld),    32'(vq[i].e_vld));
            chk("br_addr",   i, br_addr,        vq[i].e_addr);
            chk("br_instr",  i, br_instr,       vq[i].e_instr);
            chk("br_kind",   i, 32'(br_kind),   32'(vq[i].e_kind));
            chk("pend_cnt",  i, 32'(pend_cnt),  vq[i].e_pend);
            chk("proto_err", i, 32'(proto_err), 32'(vq[i].e_perr));
            chk("beq_cnt",   i, 32'(beq_cnt),   vq[i].e_beq);
            chk("bne_cnt",   i, 32'(bne_cnt),   vq[i].e_bne);
            chk("blt_cnt",   i, 32'(blt_cnt),   vq[i].e_blt);
            chk("bltu_cnt",  i, 32'(bltu_cnt),  vq[i].e_bltu);
            chk("err_cnt",   i, 32'(err_cnt),   vq[i].e_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scr1_imem_branch_tracer.md
# scr1_imem_branch_tracer

Bus-side tracer on the SCR1 instruction-memory interface, between the core's imem port and the AHB imem bridge. It pairs each accepted fetch request with its in-order response and decodes returned words for conditional branches. It emits a registered trace record (fetch address, instruction, kind) per branch and keeps saturating per-kind counters. It is the address-accurate front end for branch-detection monitors: records carry the true fetch address rather than the pipeline PC.

## Interface
Parameters:
- DEPTH, 4: pending-request FIFO entries, power of two, 2..16.
- CNT_W, 32: counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- imem_req  in  1  core fetch request.
- imem_req_ack  in  1  bridge accepts request; transfer when imem_req & imem_req_ack.
- imem_addr  in  32  request address, sampled at transfer.
- imem_resp  in  2  00 not ready, 01 ready OK, 10 ready error, 11 reserved (treated as error).
- imem_rdata  in  32  read data, valid when imem_resp==01.
- cnt_clr  in  1  synchronous clear of all counters and proto_err.
- br_vld  out  1  one-cycle pulse: trace record valid.
- br_addr  out  32  fetch address of the branch word.
- br_instr  out  32  branch instruction word.
- br_kind  out  2  00 BEQ, 01 BNE, 10 BLT/BGE, 11 BLTU/BGEU.
- beq_cnt, bne_cnt, blt_cnt, bltu_cnt  out  CNT_W  saturating per-kind counts.
- err_cnt  out  CNT_W  saturating count of error responses.
- pend_cnt  out  $clog2(DEPTH)+1  outstanding requests.
- proto_err  out  1  sticky protocol violation flag.

## Operation
- Pending FIFO stores imem_addr; push on transfer, pop on any response (imem_resp != 00).
- Response 01 with pending entry: decode imem_rdata. It is a branch when [1:0]==11, [6:2]==11000 and funct3 [14:12] is in {000,001,100,101,110,111}. Kind = {f3[2], f3[2] ? f3[1] : f3[0]}. Branch -> load br_addr from FIFO head, br_instr, br_kind, pulse br_vld, increment the matching counter.
- funct3 010/011: not a branch; no record, no count.
- Response 10/11 with pending entry: pop, err_cnt++, no record.
- Response while FIFO empty: set proto_err, no pop, no record, no count.
- Transfer while FIFO full with no same-cycle pop: set proto_err, address dropped, pend_cnt unchanged.
- Full FIFO with simultaneous pop and push: both take effect, no error.
- Empty FIFO with simultaneous push and response: error case (the response precedes its request); set proto_err, push still performed.
- Counters saturate at all-ones and never wrap. cnt_clr has priority over a same-cycle increment (result 0). cnt_clr does not touch the FIFO or trace outputs.
- Pointers wrap modulo DEPTH. pend_cnt = push count minus pop count.

## Timing
- All outputs are registered.
- br_vld asserts in the cycle after the response cycle, for exactly one cycle. br_addr, br_instr and br_kind hold until the next record.
- Counters update one cycle after the response cycle. pend_cnt updates one cycle after the transfer or response.
- Back-to-back responses yield back-to-back br_vld pulses, one per branch.
- Reset: br_vld=0, br_addr=0, br_instr=0, br_kind=0, all counters 0, pend_cnt=0, proto_err=0, FIFO empty.
- A response or request in the reset cycle is discarded.
- Reset mid-burst flushes pending entries. A later response then sets proto_err, as specified.

## Test plan
- Single fetch addr 0x200 acked, next cycle resp=01 rdata=0x00B51463 (bne a0,a1,+8) -> next cycle br_vld=1, br_addr=0x200, br_kind=01, bne_cnt=1, pend_cnt=0.
- Four pipelined requests 0x100,0x104,0x108,0x10C, then responses BEQ 0x00000063, addi 0x00100093, BLTU 0x0000E063, error -> records at 0x100 (kind 00) and 0x108 (kind 11); beq_cnt=1, bltu_cnt=1, err_cnt=1, pend_cnt 4->0.
- resp=01 with FIFO empty -> proto_err=1, no br_vld, all counters unchanged.
- DEPTH=4 full, fifth transfer with no pop -> proto_err=1, pend_cnt=4. Same case with a same-cycle response -> no error, pend_cnt=4, head order preserved.
- CNT_W=4: issue 20 BNE fetches -> bne_cnt saturates at 15. cnt_clr coincident with a BNE response -> bne_cnt=0 next cycle.
- Assert rst with 2 pending requests, deassert, then send one response -> all outputs at reset values, then proto_err=1 after the response.
